// File: rtl/rr_mux_nx1_pkg.sv
// Shared definitions for the N:1 registered round-robin multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            r = r + 1;
            v = v << 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_nx1_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping at N.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            int idx;
            idx = int'(ptr) + j;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_nx1.sv
// N-channel W-bit registered multiplexer with manual or round-robin selection
// and valid/ready handshakes on every channel and on the output.
module rr_mux_nx1
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int W  = 8,
    localparam int SW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  s,
    input  logic [N*W-1:0] i,
    input  logic [N-1:0]   iv,
    output logic [N-1:0]   ir,
    output logic [W-1:0]   y,
    output logic           yv,
    input  logic           yr,
    output logic [SW-1:0]  ych
);

    logic          accept;
    logic          man_vld;
    logic          rr_vld;
    logic [SW-1:0] rr_idx;
    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic          xfer;

    logic [W-1:0]  y_q,   y_d;
    logic          yv_q,  yv_d;
    logic [SW-1:0] ych_q, ych_d;
    logic [SW-1:0] ptr_q, ptr_d;

    rr_pick #(.N(N)) u_pick (
        .req     (iv),
        .ptr     (ptr_q),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    always_comb begin
        // Select values beyond the channel count never grant.
        man_vld = (int'(s) < N) && iv[s];
        if (mode == MODE_RR) begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end else begin
            gnt_vld = man_vld;
            gnt_idx = s;
        end
        accept = !rst && (!yv_q || yr);
        xfer   = accept && gnt_vld;
        ir     = xfer ? (N'(1) << gnt_idx) : '0;
    end

    always_comb begin
        y_d   = y_q;
        yv_d  = yv_q;
        ych_d = ych_q;
        ptr_d = ptr_q;
        if (xfer) begin
            y_d   = i[int'(gnt_idx)*W +: W];
            ych_d = gnt_idx;
            yv_d  = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SW'(1);
            end
        end else if (yr) begin
            yv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            yv_q  <= 1'b0;
            ych_q <= '0;
            ptr_q <= '0;
        end else begin
            y_q   <= y_d;
            yv_q  <= yv_d;
            ych_q <= ych_d;
            ptr_q <= ptr_d;
        end
    end

    assign y   = y_q;
    assign yv  = yv_q;
    assign ych = ych_q;

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Randomised and directed bench for rr_mux_nx1 against a behavioural model.
module tb_rr_mux_nx1;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [SW-1:0]  s;
    logic [N*W-1:0] i;
    logic [N-1:0]   iv;
    logic [N-1:0]   ir;
    logic [W-1:0]   y;
    logic           yv;
    logic           yr;
    logic [SW-1:0]  ych;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  m_y;
    logic          m_yv;
    logic [SW-1:0] m_ych;
    int            m_ptr;

    rr_mux_nx1 #(.N(N), .W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .s    (s),
        .i    (i),
        .iv   (iv),
        .ir   (ir),
        .y    (y),
        .yv   (yv),
        .yr   (yr),
        .ych  (ych)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel the model would grant this cycle, or -1.
    function automatic int pick();
        if (m_yv && !yr) return -1;
        if (mode == 1'b0) return iv[s] ? int'(s) : -1;
        for (int k = 0; k < N; k++) begin
            if (iv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input string tag);
        int           g;
        logic [N-1:0] eir;
        #1;
        g   = pick();
        eir = (g >= 0) ? (N'(1) << g) : '0;
        chk({tag, "_ir"}, 32'(ir), 32'(eir));
        @(posedge clk);
        if (g >= 0) begin
            m_y   = i[g*W +: W];
            m_ych = SW'(g);
            m_yv  = 1'b1;
            if (mode) m_ptr = (g + 1) % N;
        end else if (yr) begin
            m_yv = 1'b0;
        end
        #1;
        chk({tag, "_y"},   32'(y),   32'(m_y));
        chk({tag, "_yv"},  32'(yv),  32'(m_yv));
        chk({tag, "_ych"}, 32'(ych), 32'(m_ych));
    endtask

    task automatic model_reset();
        m_y   = '0;
        m_yv  = 1'b0;
        m_ych = '0;
        m_ptr = 0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; s = '0; i = '0; iv = '0; yr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y",  32'(y),  0);
        chk("rst_yv", 32'(yv), 0);
        chk("rst_ir", 32'(ir), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Manual select of a valid channel.
        mode = 1'b0; s = 3'd5; iv = 8'h20; yr = 1'b1;
        i = {$urandom, $urandom};
        i[5*W +: W] = 8'hA5;
        cycle("man");
        chk("man_y",   32'(y),   32'h A5);
        chk("man_ych", 32'(ych), 5);

        // Manual select of an idle channel: no grant, held word drains.
        s = 3'd3; iv = 8'hF7;
        cycle("man_idle");
        chk("man_idle_yv", 32'(yv), 0);

        // Round-robin under full load.
        mode = 1'b1; iv = 8'hFF;
        for (int k = 0; k < N; k++) i[k*W +: W] = W'(8'h10 + k);
        for (int n = 0; n < 10; n++) begin
            cycle("rr_full");
            chk("rr_full_seq", 32'(ych), n % N);
            chk("rr_full_dat", 32'(y), 32'h10 + (n % N));
        end

        // Grant to 5, then sparse requests wrap to 0/1.
        iv = 8'h20;
        cycle("rr_five");
        iv = 8'h03;
        for (int n = 0; n < 4; n++) begin
            cycle("rr_wrap");
            chk("rr_wrap_seq", 32'(ych), n % 2);
        end

        // Backpressure holds the word and all readies.
        iv = 8'hFF;
        for (int k = 0; k < N; k++) i[k*W +: W] = 8'h3C;
        cycle("bp_load");
        chk("bp_load_ych", 32'(ych), 2);
        yr = 1'b0;
        for (int n = 0; n < 3; n++) begin
            i = {$urandom, $urandom};
            cycle("bp_hold");
            chk("bp_hold_y", 32'(y), 32'h3C);
        end
        yr = 1'b1;
        cycle("bp_release");
        chk("bp_release_ych", 32'(ych), 3);
        chk("bp_release_yv",  32'(yv), 1);

        // Asynchronous reset mid-stream.
        i = {$urandom, $urandom};
        cycle("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_y",   32'(y),   0);
        chk("arst_yv",  32'(yv),  0);
        chk("arst_ych", 32'(ych), 0);
        chk("arst_ir",  32'(ir),  0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mode = 1'b1; iv = 8'hFF; yr = 1'b1;
        cycle("post_rst");
        chk("post_rst_ych", 32'(ych), 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            mode = 1'($urandom_range(0, 1));
            s    = SW'($urandom_range(0, N - 1));
            iv   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            i    = {$urandom, $urandom};
            yr   = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_nx1.md
Name: rr_mux_nx1

Overview:
- Parametrised N-channel, W-bit registered multiplexer. Successor to the fixed 8:1 gate-level mux.
- Each channel has a valid/ready handshake. The single output is a registered word with its own valid/ready.
- Two modes: manual select, where the select input chooses the channel, and round-robin, where a rotating pointer arbitrates between valid channels.
- Sits between several producer streams and one consumer. Throughput is one word per clock.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 8, data width per channel.
- SW, $clog2(N), select/channel-id width. Derived localparam; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = manual select, 1 = round-robin.
- s  input  SW  manual channel select; used only when mode=0.
- i  input  N*W  channel data; channel k occupies i[k*W +: W].
- iv  input  N  per-channel valid.
- ir  output  N  per-channel ready; combinational; at most one bit set.
- y  output  W  registered output data.
- yv  output  1  output valid.
- yr  input  1  consumer ready.
- ych  output  SW  channel id of the word currently held in y.

Behaviour:
- Reset (asynchronous, active-high): y=0, yv=0, ych=0, round-robin pointer ptr=0. A held word is discarded; no ir is asserted while rst=1.
- accept = rst==0 && (yv==0 || yr==1). The output stage takes a new word only when it is empty or is being drained in the same cycle.
- Grant selection (combinational):
  - mode=0: grant channel s if s<N and iv[s]=1. Otherwise no grant. s>=N never grants.
  - mode=1: grant the first k with iv[k]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1. No valid channel means no grant.
- ir[g] = accept && grant valid && g==granted channel. All other ir bits are 0. ir never depends on yr while yv=0.
- Transfer on channel g (ir[g]=1, which implies iv[g]=1):
  - Next edge: y <= i[g*W +: W], ych <= g, yv <= 1.
  - Latency is one clock from the input handshake to yv.
- Drain without a new grant (yv=1, yr=1, no grant): yv <= 0. y and ych hold their last values.
- Simultaneous drain and grant: the new word replaces the old in the same edge and yv stays 1. Full rate, no bubble.
- Backpressure (yv=1, yr=0): y, yv, ych and ptr hold; all ir are 0.
- Pointer:
  - Updates only on a mode=1 transfer: ptr <= (g==N-1) ? 0 : g+1. This is the wrap-around case.
  - No mode=1 transfer means ptr holds, including during backpressure and with no valid channels.
  - Manual-mode transfers never move ptr.
- Mode or select change: sampled each cycle. It takes effect on the next accept cycle. A word already in y is unaffected.
- Input data is sampled only on the transfer edge; i may change freely otherwise.

Decomposition:
- Shared package mux_pkg:
  - MODE_MANUAL = 1'b0, MODE_RR = 1'b1.
  - Function clog2 for elaboration-time SW.
- One combinational sub-module, rr_pick.
  - Parameter N. Inputs: req[N-1:0], ptr[SW-1:0].
  - Outputs: gnt_vld, gnt_idx[SW-1:0].
  - Function: rotating-priority search starting at ptr.
- The top level holds the mode mux, the output register, ptr, and the ir decode.

Test Plan (N=8, W=8):
1. Reset: run traffic, then pulse rst for 1 cycle mid-transfer with yv=1 -> immediately y=8'h00, yv=0, ych=0, ir=8'h00. After release, with mode=1 and iv=8'hFF, the first grant is channel 0.
2. Manual select: mode=0, s=5, iv=8'h20, channel 5 data=8'hA5, yr=1 -> ir=8'h20 in the same cycle; next cycle y=8'hA5, ych=5, yv=1.
3. Manual, select not valid: mode=0, s=3, iv=8'hF7 -> ir=8'h00. A held word drains with yr=1 and yv falls to 0 the next cycle.
4. Round-robin full load: mode=1, iv=8'hFF, yr=1 held, channel k data=8'h10+k -> ych sequence 0,1,2,...,7,0,1 on consecutive cycles; y=8'h10..8'h17; yv continuously 1.
5. Round-robin wrap with sparse requests: ptr=6 (after a grant to 5), iv=8'h03 -> grants 0, 1, 0, 1. Channels 6 and 7 are never granted; ptr goes 1, 2, 1, 2.
6. Backpressure: yv=1, y=8'h3C, yr=0 for 3 cycles with iv=8'hFF -> y=8'h3C stable, ir=8'h00, ptr unchanged. Raise yr=1 -> the same cycle asserts one ir bit (next in rotation) and the next cycle shows the new word with yv=1, no bubble.
